// File: rtl/csd_encoder.sv
// csd_encoder: sequential binary-to-CSD (non-adjacent form) converter.
// Produces one signed digit per clock, least-significant first. Each digit is
// written into a 16-entry digit memory through weCsd/address/dataIn.
// Digit encoding: +1 = 8'h01, 0 = 8'h00, -1 = 8'hFF.
// Optional build macro: CSD_SIGNED_EN. When it is defined, binIn is treated as
// two's complement and sign-extended. Otherwise binIn is unsigned and zero-extended.
//
// Handshake: start is sampled only in IDLE. When start is accepted, binIn is
// latched, and the next NDIG cycles carry one write each (weCsd=1). done then
// pulses for one cycle. start seen while busy or in DONE is dropped, not queued.
module csd_encoder #(
    parameter int NDIG = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] binIn,
    output logic       weCsd,
    output logic [3:0] address,
    output logic [7:0] dataIn,
    output logic       busy,
    output logic       done,
    output logic [3:0] nzCount,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NDIG - 1);

    state_t      state;
    logic [9:0]  x;
    logic [3:0]  count;

    logic [9:0]  x_load;
    logic [9:0]  step_src;
    logic [9:0]  step_x;
    logic [7:0]  step_digit;
    logic        step_nz;

`ifdef CSD_SIGNED_EN
    assign x_load = {{2{binIn[7]}}, binIn};
`else
    assign x_load = {2'b00, binIn};
`endif

    assign fsm_state = state;

    // Single NAF digit step. On the accept edge, the step uses the freshly
    // extended operand, so digit 0 is already on the write port in the first
    // busy cycle. Afterwards, the step uses the working register.
    always_comb begin
        step_src   = (state == IDLE) ? x_load : x;
        step_digit = 8'h00;
        step_nz    = 1'b0;
        step_x     = 10'($signed(step_src) >>> 1);
        case (step_src[1:0])
            2'b01: begin
                step_digit = 8'h01;
                step_nz    = 1'b1;
                step_x     = 10'($signed(step_src - 10'd1) >>> 1);
            end
            2'b11: begin
                step_digit = 8'hFF;
                step_nz    = 1'b1;
                step_x     = 10'($signed(step_src + 10'd1) >>> 1);
            end
            default: ;
        endcase
    end

    // Control FSM with registered write port, status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            x       <= '0;
            count   <= '0;
            weCsd   <= 1'b0;
            address <= '0;
            dataIn  <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            nzCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ENC;
                        x       <= step_x;
                        dataIn  <= step_digit;
                        address <= '0;
                        weCsd   <= 1'b1;
                        busy    <= 1'b1;
                        count   <= {3'b000, step_nz};
                    end
                end
                ENC: begin
                    if (address == LAST_IDX) begin
                        state   <= DONE;
                        weCsd   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dataIn  <= 8'h00;
                        nzCount <= count;
                    end else begin
                        x       <= step_x;
                        dataIn  <= step_digit;
                        address <= address + 4'd1;
                        count   <= count + {3'b000, step_nz};
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    address <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/csd_encoder.md
# csd_encoder

Sequential binary-to-CSD (canonical signed digit / non-adjacent form) converter that sits directly upstream of the CSD datapath. It accepts one 8-bit operand and computes one CSD digit per clock, least-significant first. It writes each digit into the datapath's 16-entry digit memory through the datapath's memory write port. Digit encoding matches the datapath's `Zcsd` detection: `+1 = 8'h01`, `0 = 8'h00`, `-1 = 8'hFF`.

## Interface
Parameters:
- `NDIG`, 16: digits written per conversion; equals the memory depth; address width is 4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `binIn`  in  8  operand; latched on an accepted `start`.
- `weCsd`  out  1  memory write enable; drives the datapath `weCsd`.
- `address`  out  4  memory write address; drives the datapath `address`.
- `dataIn`  out  8  digit value; drives the datapath `dataIn`.
- `busy`  out  1  high from the accept cycle through the last write.
- `done`  out  1  one-cycle pulse after the last write.
- `nzCount`  out  4  number of nonzero digits in the last completed conversion.

## Operation
- FSM states: IDLE, ENC, DONE.
- IDLE:
  - `start=1` latches `binIn` into a 10-bit working register `x`.
  - Without the configuration macro, `binIn` is zero-extended into `x`.
  - Clears the digit index and the running nonzero count.
  - Next state is ENC.
- ENC: performs one digit step per cycle, selected from `x[1:0]`:
  - `x[0]=0`: digit `8'h00`; `x <= x>>>1`.
  - `x[1:0]=2'b01`: digit `8'h01`; `x <= (x-1)>>>1`.
  - `x[1:0]=2'b11`: digit `8'hFF`; `x <= (x+1)>>>1`.
  - `>>>` is an arithmetic shift. All arithmetic is 10-bit two's complement and never overflows for 8-bit operands.
  - Each cycle: `weCsd=1`, `address` = digit index, `dataIn` = digit.
  - The index increments each cycle. The running count increments on every nonzero digit.
  - After index 15 is written, next state is DONE.
  - Once `x` reaches 0, the remaining digits are `8'h00`. All 16 locations are always written, so stale digits are overwritten.
- DONE:
  - `done=1` for one cycle.
  - `nzCount` takes the final count.
  - Next state is IDLE.
- `start` asserted in ENC or DONE is ignored. It is not queued.
- `binIn` changes after acceptance have no effect.
- Output rule: no two adjacent digits are nonzero, and Σ digit·2^addr = operand.
- Reset values: state IDLE, `weCsd=0`, `address=0`, `dataIn=8'h00`, `busy=0`, `done=0`, `nzCount=0`, `x=0`.
- Reset mid-conversion: on the next edge the FSM returns to IDLE and `weCsd` drops to 0. Partially written memory is left as is. `nzCount` clears to 0.
- Reset has priority over `start` in the same cycle.

## Timing
- Cycle 0: `start=1` sampled in IDLE.
- Cycles 1–16: `weCsd=1`, `address` 0..15, `busy=1`.
- Cycle 17: `done=1`, `busy=0`, `weCsd=0`, `nzCount` valid.
- Cycle 18: IDLE. The earliest next accept is a `start` sampled in cycle 18.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Conversion latency is 17 cycles from the accepting edge to `done`. Throughput is one operand per 18 cycles.
- `nzCount` holds until the next `done` or `reset`.

## Configuration
- `CSD_SIGNED_EN` defined:
  - `binIn` is two's-complement and is sign-extended into `x`.
  - The range is −128..127; negative operands produce a valid NAF.
  - Example: `8'hFF` gives −1, a single `8'hFF` digit at address 0.
- `CSD_SIGNED_EN` undefined:
  - `binIn` is unsigned, range 0..255. The top digit index used is at most 8.
- The FSM, timing and interface are identical in both builds.

## Test plan
- Reset, then `start` with `binIn=8'h07` (both builds):
  - Writes address 0 = `8'hFF`, address 3 = `8'h01`; all other addresses `8'h00`.
  - `done` at cycle 17; `nzCount=2`.
- `binIn=8'h55`:
  - Addresses 0, 2, 4, 6 = `8'h01`; all others `8'h00`.
  - `nzCount=4`.
- `binIn=8'h00`:
  - 16 writes of `8'h00`; `nzCount=0`; `done` still at cycle 17.
- `binIn=8'hFF`, unsigned build:
  - Address 0 = `8'hFF`, address 8 = `8'h01`; `nzCount=2`.
- `binIn=8'hFF`, `CSD_SIGNED_EN` build:
  - Only address 0 = `8'hFF`; `nzCount=1`.
- `start` pulsed at cycle 5 of a conversion: ignored, and exactly 16 writes occur. Then `reset` asserted at cycle 9 of a new conversion:
  - Next cycle: `weCsd=0`, `busy=0`, `nzCount=0`.
  - No `done` pulse.
